// File: rtl/vector_dot_pipe_pkg.sv
// ----------------------------------------------------------------------------
// vector_dot_pipe_pkg
// Shared constants and helpers for the pipelined fixed-point dot product.
//   - DOT_D / DOT_Q / DOT_N : default element format Q(D).(Q) and vector length
//   - DOT_W / DOT_G         : default element width and adder-tree depth
//   - clog2, level_cnt      : tree sizing helpers
//   - max_w, min_w          : signed saturation limits of a w-bit value
//   - ROUND_EN              : set by the DOT_ROUND_EN macro (round half up
//                             instead of truncating each product)
// ----------------------------------------------------------------------------
package vector_dot_pipe_pkg;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of operands at adder-tree level k for n leaves.
  function automatic int level_cnt(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  function automatic longint max_w(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint min_w(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam int DOT_D = 8;
  localparam int DOT_Q = 24;
  localparam int DOT_N = 3;
  localparam int DOT_W = DOT_D + DOT_Q;
  localparam int DOT_G = clog2(DOT_N);

`ifdef DOT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

endpackage

// File: rtl/fixed_mul_scale.sv
// ----------------------------------------------------------------------------
// fixed_mul_scale
// One registered signed fixed-point multiply: (i_a * i_b) >>> Q, clipped to
// W+1 bits. With DOT_ROUND_EN defined, 2^(Q-1) is added before the shift.
// Ports:
//   clk  - rising-edge clock
//   i_en - capture enable (pipeline advance)
//   i_a  - W-bit signed operand
//   i_b  - W-bit signed operand
//   o_p  - W+1-bit signed scaled product, registered
// ----------------------------------------------------------------------------
module fixed_mul_scale
  import vector_dot_pipe_pkg::*;
#(
  parameter int W = DOT_W,
  parameter int Q = DOT_Q
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W:0]   o_p
);

  // One spare bit so the rounding increment can never overflow.
  localparam int PW = 2 * W + 1;
  localparam logic signed [PW-1:0] P_MAX  = PW'(max_w(W + 1));
  localparam logic signed [PW-1:0] P_MIN  = PW'(min_w(W + 1));
  localparam logic signed [PW-1:0] P_HALF = PW'(longint'(1) <<< (Q - 1));

  logic signed [PW-1:0] w_full;
  logic signed [PW-1:0] w_shift;
  logic signed [W:0]    w_clip;

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a value on every path, so no latch is inferred.
  always_comb begin
    w_full = PW'(i_a) * PW'(i_b);
    w_full = w_full + (ROUND_EN ? P_HALF : '0);
    w_shift = w_full >>> Q;
    if (w_shift > P_MAX)      w_clip = P_MAX[W:0];
    else if (w_shift < P_MIN) w_clip = P_MIN[W:0];
    else                      w_clip = w_shift[W:0];
  end

  // NOTE: pure datapath register with no reset; the matching valid bit in the
  // parent is reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (i_en) o_p <= w_clip;
  end

endmodule

// File: rtl/vector_dot_pipe.sv
// ----------------------------------------------------------------------------
// vector_dot_pipe
// Fully pipelined signed Q(D).(Q) dot product of two N-element vectors with a
// valid/ready handshake, registered adder tree and saturating output.
// Latency 3+clog2(N) cycles; the whole pipe stalls while the output is held.
// Optional macro: DOT_ROUND_EN (round-half-up products instead of truncation).
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   in_valid  - input pair valid
//   in_ready  - pipe can accept this cycle (= !out_valid || out_ready)
//   v1, v2    - packed vectors, element i at [(D+Q)*i +: (D+Q)]
//   out_valid - r/sat valid
//   out_ready - downstream accepts
//   r         - saturated dot product
//   sat       - r was clipped
// ----------------------------------------------------------------------------
module vector_dot_pipe
  import vector_dot_pipe_pkg::*;
#(
  parameter int D = DOT_D,
  parameter int Q = DOT_Q,
  parameter int N = DOT_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*(D+Q)-1:0] v1,
  input  logic [N*(D+Q)-1:0] v2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D+Q-1:0]     r,
  output logic               sat
);

  localparam int W  = D + Q;
  localparam int G  = clog2(N);
  localparam int SW = W + 1 + G;   // exact sum width
  localparam logic signed [SW-1:0] S_MAX = SW'(max_w(W));
  localparam logic signed [SW-1:0] S_MIN = SW'(min_w(W));
  localparam logic [W-1:0]         R_MAX = W'(max_w(W));
  localparam logic [W-1:0]         R_MIN = W'(min_w(W));

  logic              w_adv;
  logic [N*W-1:0]    r_v1;
  logic [N*W-1:0]    r_v2;
  // r_vld[0]: stage-0 inputs, r_vld[1]: products, r_vld[1+k]: tree level k.
  logic [G+1:0]      r_vld;
  logic signed [W:0] w_prod [N];

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_v1 <= v1;
      r_v2 <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_vld <= '0;
    else if (w_adv) r_vld <= {r_vld[G:0], in_valid};
  end

  for (genvar i = 0; i < N; i++) begin : g_mul
    fixed_mul_scale #(.W(W), .Q(Q)) u_mul (
      .clk  (clk),
      .i_en (w_adv),
      .i_a  (r_v1[W*i +: W]),
      .i_b  (r_v2[W*i +: W]),
      .o_p  (w_prod[i])
    );
  end

  // Adder tree. Every node is held at the final exact width; level 0 aliases
  // the registered products, each further level is one register stage.
  for (genvar k = 0; k <= G; k++) begin : g_lvl
    localparam int CNT = level_cnt(N, k);
    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic signed [SW-1:0] r_sum;
      if (k == 0) begin : g_leaf
        assign r_sum = SW'(w_prod[j]);
      end else begin : g_reg
        localparam int PCNT = level_cnt(N, k - 1);
        if (2 * j + 1 < PCNT) begin : g_add
          always_ff @(posedge clk) begin
            if (w_adv) r_sum <= g_lvl[k-1].g_node[2*j].r_sum + g_lvl[k-1].g_node[2*j+1].r_sum;
          end
        end else begin : g_pass
          // Odd leftover operand moves up one level unchanged.
          always_ff @(posedge clk) begin
            if (w_adv) r_sum <= g_lvl[k-1].g_node[2*j].r_sum;
          end
        end
      end
    end
  end

  logic signed [SW-1:0] w_sum;
  logic [W-1:0]         w_r;
  logic                 w_sat;

  assign w_sum = g_lvl[G].g_node[0].r_sum;

  always_comb begin
    w_r   = w_sum[W-1:0];
    w_sat = 1'b0;
    if (w_sum > S_MAX) begin
      w_r   = R_MAX;
      w_sat = 1'b1;
    end else if (w_sum < S_MIN) begin
      w_r   = R_MIN;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      sat       <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_vld[G+1];
      // Bubbles leave r/sat untouched so the output only shows real results.
      if (r_vld[G+1]) begin
        r   <= w_r;
        sat <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_vector_dot_pipe.sv
// ----------------------------------------------------------------------------
// tb_vector_dot_pipe
// Self-checking bench for vector_dot_pipe (N=3 main instance plus N=1/4/5
// instances for the length sweep). Expected results come from a longint
// reference model and travel through a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_vector_dot_pipe;

  localparam int LAT = 5;  // 3 + clog2(3)

  typedef struct {
    logic [31:0] r;
    logic        sat;
    int          t;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] v1;
  logic [95:0] v2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        sat;

  logic         sw_valid;
  logic         sw_ordy;
  logic         sw_rdy1, sw_rdy4, sw_rdy5;
  logic         sw_ov1, sw_ov4, sw_ov5;
  logic [31:0]  sw_r1, sw_r4, sw_r5;
  logic         sw_s1, sw_s4, sw_s5;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  bit          hold_pend = 1'b0;
  logic [31:0] hold_r;
  logic        hold_sat;

  always #5 clk = ~clk;

  vector_dot_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .v1(v1), .v2(v2), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .sat(sat)
  );

  vector_dot_pipe #(.N(1)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy1),
    .v1({1{32'h0100_0000}}), .v2({1{32'h0100_0000}}), .out_valid(sw_ov1),
    .out_ready(sw_ordy), .r(sw_r1), .sat(sw_s1)
  );

  vector_dot_pipe #(.N(4)) dut_n4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy4),
    .v1({4{32'h0100_0000}}), .v2({4{32'h0100_0000}}), .out_valid(sw_ov4),
    .out_ready(sw_ordy), .r(sw_r4), .sat(sw_s4)
  );

  vector_dot_pipe #(.N(5)) dut_n5 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy5),
    .v1({5{32'h0100_0000}}), .v2({5{32'h0100_0000}}), .out_valid(sw_ov5),
    .out_ready(sw_ordy), .r(sw_r5), .sat(sw_s5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [95:0] vec3(input logic [31:0] a0, input logic [31:0] a1,
                                       input logic [31:0] a2);
    return {a2, a1, a0};
  endfunction

  // Reference: per-element product, optional round, >>> 24, clip to 33 bits,
  // exact sum, saturate to 32 bits.
  function automatic exp_t model(input logic [95:0] a, input logic [95:0] b);
    exp_t   e;
    longint s = 0;
    longint p;
    for (int i = 0; i < 3; i++) begin
      p = longint'($signed(a[32*i +: 32])) * longint'($signed(b[32*i +: 32]));
`ifdef DOT_ROUND_EN
      p = p + (64'sd1 <<< 23);
`endif
      p = p >>> 24;
      if (p > 64'sd4294967295)       p = 64'sd4294967295;
      else if (p < -64'sd4294967296) p = -64'sd4294967296;
      s = s + p;
    end
    e.t = 0;
    e.chk_lat = 1'b0;
    if (s > 64'sd2147483647) begin
      e.r = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.r = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.r = s[31:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  // One clock cycle on the main DUT: drive, sample at negedge, score.
  task automatic cycle(input bit iv, input logic [95:0] a, input logic [95:0] b,
                       input bit ordy, input bit lat_chk, output bit fired);
    exp_t e;
    in_valid  = iv;
    v1        = a;
    v2        = b;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (hold_pend) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_r", r, hold_r);
      check("hold_sat", sat, hold_sat);
    end
    hold_pend = out_valid && !out_ready;
    hold_r    = r;
    hold_sat  = sat;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("r", r, e.r);
        check("sat", sat, e.sat);
        if (e.chk_lat) check("latency", cyc - e.t, LAT);
      end
    end
    fired = iv && in_ready;
    if (fired) begin
      e = model(a, b);
      e.t = cyc;
      e.chk_lat = lat_chk;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [95:0] a, input logic [95:0] b);
    bit f = 1'b0;
    int guard = 0;
    while (!f && guard < 20) begin
      cycle(1'b1, a, b, 1'b1, 1'b1, f);
      guard++;
    end
    check("send_accepted", f, 1'b1);
  endtask

  task automatic drain();
    bit f;
    int guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, f);
      guard++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit          f;
    int          sent;
    int          lat1, lat4, lat5;
    logic [31:0] rr1, rr4, rr5;
    logic        ss1, ss4, ss5;
    logic [31:0] ea[3];
    logic [31:0] eb[3];

    rst = 1'b0; in_valid = 1'b0; v1 = '0; v2 = '0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_r", r, 32'h0);
    check("rst_sat", sat, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed, back-to-back, no stall: latency checked on each.
    send(vec3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
         vec3(32'h0400_0000, 32'h0500_0000, 32'h0600_0000));
    send({3{32'h7F00_0000}}, {3{32'h7F00_0000}});
    send({3{32'h7F00_0000}}, {3{32'h8100_0000}});
    send(vec3(32'h0000_0001, 32'h0, 32'h0), vec3(32'h0080_0000, 32'h0, 32'h0));
    send(vec3(32'hFFFF_FFFF, 32'h0, 32'h0), vec3(32'h0080_0000, 32'h0, 32'h0));
    send(vec3(32'hFE80_0000, 32'h0240_0000, 32'h0080_0000),
         vec3(32'h0300_0000, 32'hFF00_0000, 32'h07C0_0000));
    drain();

    // Spot checks of the headline values against fixed constants.
    send(vec3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
         vec3(32'h0400_0000, 32'h0500_0000, 32'h0600_0000));
    drain();
    check("basic_r_const", r, 32'h2000_0000);
    check("basic_sat_const", sat, 1'b0);

    // Random stream with backpressure, including two 5-cycle stall bursts.
    sent = 0;
    for (int c = 0; c < 500 && sent < 20; c++) begin
      bit ordy;
      for (int i = 0; i < 3; i++) begin
        ea[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
        eb[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
      end
      ordy = ((c >= 4 && c < 9) || (c >= 18 && c < 23)) ? 1'b0 : 1'($urandom_range(0, 1));
      cycle(1'b1, vec3(ea[0], ea[1], ea[2]), vec3(eb[0], eb[1], eb[2]), ordy, 1'b0, f);
      if (f) sent++;
    end
    check("stream_sent", sent, 20);
    drain();

    // Reset with four results in flight.
    send(vec3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
         vec3(32'h0400_0000, 32'h0500_0000, 32'h0600_0000));
    drain();
    for (int i = 0; i < 4; i++)
      send(vec3(32'h0100_0000 * (i + 1), 32'h0, 32'h0), vec3(32'h0100_0000, 32'h0, 32'h0));
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_r", r, 32'h0);
    check("mid_rst_sat", sat, 1'b0);
    sb.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, f);
    send(vec3(32'h0080_0000, 32'h0100_0000, 32'hFF00_0000),
         vec3(32'h0200_0000, 32'h0300_0000, 32'h0100_0000));
    drain();

    // Vector-length sweep: all elements 1.0 on N=1,4,5 instances.
    lat1 = -1; lat4 = -1; lat5 = -1;
    rr1 = '0; rr4 = '0; rr5 = '0; ss1 = 1'b0; ss4 = 1'b0; ss5 = 1'b0;
    sw_valid = 1'b1;
    @(negedge clk);
    check("sw_in_ready", {sw_rdy1, sw_rdy4, sw_rdy5}, 3'b111);
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (sw_ov1 && lat1 < 0) begin lat1 = k; rr1 = sw_r1; ss1 = sw_s1; end
      if (sw_ov4 && lat4 < 0) begin lat4 = k; rr4 = sw_r4; ss4 = sw_s4; end
      if (sw_ov5 && lat5 < 0) begin lat5 = k; rr5 = sw_r5; ss5 = sw_s5; end
      @(posedge clk);
      #1;
    end
    check("n1_lat", lat1, 3);
    check("n1_r", rr1, 32'h0100_0000);
    check("n1_sat", ss1, 1'b0);
    check("n4_lat", lat4, 5);
    check("n4_r", rr4, 32'h0400_0000);
    check("n4_sat", ss4, 1'b0);
    check("n5_lat", lat5, 6);
    check("n5_r", rr5, 32'h0500_0000);
    check("n5_sat", ss5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
